// File: rtl/nic_pkg.sv
// Shared constants and helpers for the cmp processor network interface.
// Bit numbers follow the processor's big-endian convention (bit 0 = MSB).
package nic_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_IBUF  = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_ISTAT = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_OBUF  = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_OSTAT = 2'b11;

  localparam int unsigned STATUS_FULL_BIT = 63;
  localparam int unsigned PKT_VC_BIT      = 0;

  // Vectors are declared [DATA_W-1:0]; big-endian bit n sits at index DATA_W-1-n.
  localparam int unsigned STATUS_FULL_IDX = DATA_W - 1 - STATUS_FULL_BIT;
  localparam int unsigned PKT_VC_IDX      = DATA_W - 1 - PKT_VC_BIT;

  function automatic logic [DATA_W-1:0] status_word(input logic full);
    logic [DATA_W-1:0] w;
    w = '0;
    w[STATUS_FULL_IDX] = full;
    return w;
  endfunction

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry 64-bit channel buffer with a full flag.
// Load wins over clear; the top never asserts both on one edge except a read of an empty buffer.
module nic_chan_buf
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              full
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cmp_nic.sv
// Network interface between the cmp data-memory port and the ring router:
// one output-channel and one input-channel buffer, memory-mapped to the processor.
module cmp_nic
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  logic [DATA_W-1:0] ibuf;
  logic [DATA_W-1:0] obuf;
  logic [DATA_W-1:0] rd_data;
  logic              in_full;
  logic              out_full;
  logic              rd_en;
  logic              rd_ibuf;
  logic              wr_obuf;
  logic              inject;
  logic              eject;

  assign net_ri  = ~in_full;
  assign rd_en   = nicEn & ~nicWrEn;
  assign rd_ibuf = rd_en & (addr == ADDR_IBUF);
  // A write to a full output buffer is dropped, even when it drains on the same edge.
  assign wr_obuf = nicEn & nicWrEn & (addr == ADDR_OBUF) & ~out_full;
  assign inject  = out_full & net_ro & (net_polarity == obuf[PKT_VC_IDX]);
  assign eject   = net_si & ~in_full;

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_IBUF:  rd_data = ibuf;
      ADDR_ISTAT: rd_data = status_word(in_full);
      ADDR_OBUF:  rd_data = '0;
      ADDR_OSTAT: rd_data = status_word(out_full);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out  <= '0;
      net_so <= 1'b0;
      net_do <= '0;
    end else begin
      net_so <= inject;
      if (inject) begin
        net_do <= obuf;
      end
      if (rd_en) begin
        d_out <= rd_data;
      end
    end
  end

  nic_chan_buf u_ibuf (
    .clk   (clk),
    .reset (reset),
    .load  (eject),
    .clr   (rd_ibuf),
    .d     (net_di),
    .q     (ibuf),
    .full  (in_full)
  );

  nic_chan_buf u_obuf (
    .clk   (clk),
    .reset (reset),
    .load  (wr_obuf),
    .clr   (inject),
    .d     (d_in),
    .q     (obuf),
    .full  (out_full)
  );

endmodule
